bresp_route_1_2: RTL
====================

// Module: bresp_route_1_2
// PURPOSE
//  Write-response (B channel) return path of the 2-master interconnect.
//  - Records, in issue order, which master won each AW handshake.
//  - Routes every slave B response back to that master through a one-entry output register.
//  - Counterpart of the bready select mux: it drives bvalid/bresp toward the masters,
//    and the mux collects bready from them.
// PARAMETERS
//  DEPTH    4   order-FIFO entries = max outstanding writes (power of 2, >=2)
//  CNT_W    16  width of error counters (only with BRESP_ERR_CNT_EN)
// PORTS
//  ACLK             in   1                  clock, all logic on rising edge
//  ARESET           in   1                  synchronous reset, active-high
//  aw_push_valid    in   1                  AW handshake completed for a granted master
//  aw_push_master   in   1                  granted master index (0=S00, 1=S01)
//  aw_push_ready    out  1                  order FIFO not full
//  M_AXI_bvalid     in   1                  slave response valid
//  M_AXI_bresp      in   2                  slave response code
//  M_AXI_bready     out  1                  accept slave response
//  S00_AXI_bvalid   out  1                  response valid to master 0
//  S00_AXI_bresp    out  2                  response code to master 0
//  S00_AXI_bready   in   1                  master 0 accepts
//  S01_AXI_bvalid   out  1                  response valid to master 1
//  S01_AXI_bresp    out  2                  response code to master 1
//  S01_AXI_bready   in   1                  master 1 accepts
//  outstanding      out  $clog2(DEPTH+1)    FIFO occupancy
//  err_cnt_s00/s01  out  CNT_W              SLVERR+DECERR count per master (macro only)
// BEHAVIOUR
//  Reset:
//   - FIFO empty, wr/rd pointers 0, outstanding=0, output register empty.
//   - All bvalid=0, bresp=2'b00, M_AXI_bready=0, aw_push_ready=1, err counters=0.
//   - Reset mid-transfer discards all entries and any held response; no handshake in that cycle counts.
//  Order FIFO:
//   - Push when aw_push_valid && aw_push_ready.
//   - aw_push_ready = (outstanding != DEPTH); a push while full is ignored.
//   - Push and pop in the same cycle are both honoured and outstanding is unchanged,
//     including when full (aw_push_ready is still 0 then) or when occupancy is 1.
//   - Pointers wrap modulo DEPTH.
//  Output register:
//   - States EMPTY / HOLD(master m, resp r).
//   - M_AXI_bready = (outstanding != 0) && (EMPTY || Sm_AXI_bready); combinational, no bvalid dependence.
//   - Slave handshake (M_AXI_bvalid && M_AXI_bready): pop the FIFO head m, load HOLD(m, M_AXI_bresp).
//   - Latency from slave handshake to Sm_AXI_bvalid: 1 cycle.
//   - Throughput is 1 response/cycle when the target master holds bready high.
//   - HOLD: Sm_AXI_bvalid=1, Sm_AXI_bresp=r. The other master sees bvalid=0, bresp=00.
//   - Values stay stable until Sm_AXI_bready.
//   - Master handshake with no new slave handshake: go to EMPTY. With a simultaneous
//     slave handshake: reload HOLD directly; the new target may differ.
//   - Slave bvalid with FIFO empty is not accepted (bready=0); no state change.
//  Arithmetic: outstanding is next = cur + push - pop; it never exceeds DEPTH or drops below 0.
// CONFIGURATION
//  BRESP_ERR_CNT_EN defined:
//   - err_cnt_s00/s01 exist. Each increments on a master-side handshake with bresp[1]==1.
//   - Counters saturate at all-ones and reset to 0.
//  BRESP_ERR_CNT_EN undefined: counters and ports absent; no other behaviour changes.
// TESTING
//  T1 in-order: push m0,m1,m0; slave sends OKAY,SLVERR,OKAY, masters ready
//     -> S00 gets 00; S01 gets 10; S00 gets 00; each 1 cycle after its slave handshake.
//  T2 full: push 4x m1 with no B -> outstanding=4, aw_push_ready=0.
//     5th push is ignored. Then one B and one push in the same cycle -> outstanding stays 4.
//  T3 backpressure: HOLD for m0 with S00_AXI_bready=0 for 3 cycles
//     -> S00 bvalid/bresp stable; M_AXI_bready=0; next B not accepted until S00 ready.
//  T4 empty: M_AXI_bvalid=1 with outstanding=0 -> M_AXI_bready=0 and no master bvalid, for 5 cycles.
//  T5 back-to-back: push m0,m1; both masters ready, slave bvalid continuous
//     -> S00 valid at cycle n, S01 at n+1, no bubble.
//  T6 reset: ARESET pulsed while HOLD with outstanding=2
//     -> next cycle all bvalid=0, outstanding=0, aw_push_ready=1.
//     With BRESP_ERR_CNT_EN: 3 DECERR to m1 -> err_cnt_s01=3, err_cnt_s00=0.

Source files
------------

// File: rtl/bresp_route_1_2.sv
// bresp_route_1_2: B-channel return path routing slave responses to the AW-order master; define BRESP_ERR_CNT_EN for per-master error counters.
module bresp_route_1_2 #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         aw_push_valid,
  input  logic                         aw_push_master,
  output logic                         aw_push_ready,
  input  logic                         M_AXI_bvalid,
  input  logic [1:0]                   M_AXI_bresp,
  output logic                         M_AXI_bready,
  output logic                         S00_AXI_bvalid,
  output logic [1:0]                   S00_AXI_bresp,
  input  logic                         S00_AXI_bready,
  output logic                         S01_AXI_bvalid,
  output logic [1:0]                   S01_AXI_bresp,
  input  logic                         S01_AXI_bready,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
`ifdef BRESP_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]             err_cnt_s00,
  output logic [CNT_W-1:0]             err_cnt_s01
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] order;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic hold, hold_m, sel_ready, m_hs, push, pop;
  logic [1:0] hold_r;
  assign sel_ready = hold_m ? S01_AXI_bready : S00_AXI_bready;
  assign m_hs = hold && sel_ready;
  assign M_AXI_bready = !ARESET && (outstanding != '0) && (!hold || sel_ready);
  assign pop = M_AXI_bvalid && M_AXI_bready;
  assign aw_push_ready = outstanding != OW'(DEPTH);
  // a simultaneous pop frees the slot, so a push is taken even when full
  assign push = aw_push_valid && (aw_push_ready || pop);
  assign S00_AXI_bvalid = hold && !hold_m;
  assign S01_AXI_bvalid = hold && hold_m;
  assign S00_AXI_bresp = S00_AXI_bvalid ? hold_r : 2'b00;
  assign S01_AXI_bresp = S01_AXI_bvalid ? hold_r : 2'b00;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      order       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      hold        <= 1'b0;
      hold_m      <= 1'b0;
      hold_r      <= 2'b00;
    end else begin
      if (push) begin
        order[wr_ptr] <= aw_push_master;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      outstanding <= outstanding + OW'(push) - OW'(pop);
      if (pop) begin
        hold   <= 1'b1;
        hold_m <= order[rd_ptr];
        hold_r <= M_AXI_bresp;
      end else if (m_hs) begin
        hold <= 1'b0;
      end
    end
  end
`ifdef BRESP_ERR_CNT_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_cnt_s00 <= '0;
      err_cnt_s01 <= '0;
    end else if (m_hs && hold_r[1]) begin
      if (!hold_m && !(&err_cnt_s00)) err_cnt_s00 <= err_cnt_s00 + 1'b1;
      if (hold_m && !(&err_cnt_s01)) err_cnt_s01 <= err_cnt_s01 + 1'b1;
    end
  end
`endif
endmodule
